// File: rtl/tds_chk_pkg.sv
// tds_chk_pkg: shared types and constants for the TDS receive frame checker.
package tds_chk_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } tds_state_e;

  localparam logic [9:0]  K28_5_RDN       = 10'h17C;
  localparam logic [9:0]  K28_5_RDP       = 10'h283;
  localparam logic [19:0] K28_5_SYNC_WORD = {K28_5_RDP, K28_5_RDN};

  localparam int OFF_W = 5;
  localparam int POP_W = 5;

endpackage

// File: rtl/tds_prbs7_chk.sv
// tds_prbs7_chk: PRBS-7 (x^7+x^6+1) check of one aligned word against its predecessor.
module tds_prbs7_chk
  import tds_chk_pkg::*;
(
  input  logic             gt0_rxusrclk2_out,
  input  logic             gt0_rxresetdone_out,
  input  logic [19:0]      i_prev_word,
  input  logic [19:0]      i_cur_word,
  input  logic             i_en,
  output logic [POP_W-1:0] o_err_cnt
);

  logic [39:0]      w_bits;
  logic [19:0]      w_err;
  logic [POP_W-1:0] w_pop;
  logic [POP_W-1:0] r_err_cnt;

  assign w_bits = {i_cur_word, i_prev_word};

  // Current-word bit n sits at n+20; its taps are 7 and 6 bits earlier.
  always_comb begin
    w_err = '0;
    w_pop = '0;
    for (int n = 0; n < 20; n++) begin
      w_err[n] = w_bits[n + 20] ^ w_bits[n + 13] ^ w_bits[n + 14];
      w_pop    = w_pop + POP_W'(w_err[n]);
    end
  end

  always_ff @(posedge gt0_rxusrclk2_out or negedge gt0_rxresetdone_out) begin
    if (!gt0_rxresetdone_out) begin
      r_err_cnt <= '0;
    end else begin
      r_err_cnt <= i_en ? w_pop : '0;
    end
  end

  assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/tds_rx_frame_checker.sv
// tds_rx_frame_checker: K28.5 frame aligner with frame, miss and PRBS-7 statistics.
// Define TDS_CHK_PRBS_EN to build the PRBS-7 payload checker; otherwise bit_err_cnt is 0.
module tds_rx_frame_checker
  import tds_chk_pkg::*;
#(
  parameter int          FRAME_LEN = 64,
  parameter int          LOCK_CNT  = 4,
  parameter int          MISS_MAX  = 3,
  parameter logic [19:0] SYNC_WORD = K28_5_SYNC_WORD
) (
  input  logic             gt0_rxusrclk2_out,
  input  logic             gt0_rxresetdone_out,
  input  logic [19:0]      rx_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic [OFF_W-1:0] align_off,
  output logic [19:0]      aligned_data,
  output logic             aligned_valid,
  output logic             sof,
  output logic [31:0]      frame_cnt,
  output logic [15:0]      miss_cnt,
  output logic [31:0]      bit_err_cnt
);

  localparam int               POS_W     = $clog2(FRAME_LEN);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(FRAME_LEN - 1);
  localparam logic [7:0]       GOOD_LOCK = 8'(LOCK_CNT);
  localparam logic [7:0]       MISS_LIM  = 8'(MISS_MAX);

  logic [19:0]      r_prev, r_cur, r_aligned;
  logic [39:0]      w_win;
  tds_state_e       r_state, w_state_nxt;
  logic [POS_W-1:0] r_pos, w_pos_nxt;
  logic [7:0]       r_good, w_good_nxt;
  logic [7:0]       r_miss_run, w_miss_run_nxt;
  logic [OFF_W-1:0] r_off, w_off_nxt, w_hit_off;
  logic             w_hit_any, w_wrap, w_sync_ok, w_frame_inc, w_miss_inc;
  logic [19:0]      w_aligned_nxt;
  logic [31:0]      r_frame_cnt;
  logic [15:0]      r_miss_cnt;

  assign w_win         = {r_cur, r_prev};
  assign w_wrap        = (r_pos == POS_LAST);
  assign w_sync_ok     = (20'(w_win >> r_off) == SYNC_WORD);
  assign w_aligned_nxt = 20'(w_win >> w_off_nxt);

  // Descending scan so the lowest matching offset wins.
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_off = '0;
    for (int k = 19; k >= 0; k--) begin
      if (w_win[k +: 20] == SYNC_WORD) begin
        w_hit_any = 1'b1;
        w_hit_off = OFF_W'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pos_nxt      = w_wrap ? '0 : r_pos + 1'b1;
    w_good_nxt     = r_good;
    w_miss_run_nxt = r_miss_run;
    w_off_nxt      = r_off;
    w_frame_inc    = 1'b0;
    w_miss_inc     = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_hit_any) begin
          w_state_nxt    = VERIFY;
          w_pos_nxt      = '0;
          w_good_nxt     = 8'd1;
          w_miss_run_nxt = '0;
          w_off_nxt      = w_hit_off;
        end
      end
      VERIFY: begin
        if (w_wrap) begin
          if (w_sync_ok) begin
            w_good_nxt = r_good + 8'd1;
            if (r_good + 8'd1 >= GOOD_LOCK) begin
              w_state_nxt = LOCKED;
            end
          end else begin
            w_state_nxt = HUNT;
          end
        end
      end
      LOCKED: begin
        if (w_wrap) begin
          if (w_sync_ok) begin
            w_frame_inc    = 1'b1;
            w_miss_run_nxt = '0;
          end else begin
            w_miss_inc     = 1'b1;
            w_miss_run_nxt = r_miss_run + 8'd1;
            if (r_miss_run + 8'd1 >= MISS_LIM) begin
              w_state_nxt = HUNT;
            end
          end
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge gt0_rxusrclk2_out or negedge gt0_rxresetdone_out) begin
    if (!gt0_rxresetdone_out) begin
      r_prev      <= '0;
      r_cur       <= '0;
      r_aligned   <= '0;
      r_state     <= HUNT;
      r_pos       <= '0;
      r_good      <= '0;
      r_miss_run  <= '0;
      r_off       <= '0;
      r_frame_cnt <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_prev     <= r_cur;
      r_cur      <= rx_data;
      r_aligned  <= w_aligned_nxt;
      r_state    <= w_state_nxt;
      r_pos      <= w_pos_nxt;
      r_good     <= w_good_nxt;
      r_miss_run <= w_miss_run_nxt;
      r_off      <= w_off_nxt;
      if (clr_cnt) begin
        r_frame_cnt <= '0;
        r_miss_cnt  <= '0;
      end else begin
        if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 32'd1;
        if (w_miss_inc && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
      end
    end
  end

`ifdef TDS_CHK_PRBS_EN
  logic             w_chk_en;
  logic [POP_W-1:0] w_err_pop;
  logic [32:0]      w_err_sum;
  logic [31:0]      r_bit_err_cnt;

  // Check the word about to be registered; skip sync and the word right after it.
  assign w_chk_en  = (r_state == LOCKED) && (w_pos_nxt >= POS_W'(2));
  assign w_err_sum = {1'b0, r_bit_err_cnt} + 33'(w_err_pop);

  tds_prbs7_chk u_prbs7_chk (
    .gt0_rxusrclk2_out   (gt0_rxusrclk2_out),
    .gt0_rxresetdone_out (gt0_rxresetdone_out),
    .i_prev_word         (r_aligned),
    .i_cur_word          (w_aligned_nxt),
    .i_en                (w_chk_en),
    .o_err_cnt           (w_err_pop)
  );

  always_ff @(posedge gt0_rxusrclk2_out or negedge gt0_rxresetdone_out) begin
    if (!gt0_rxresetdone_out) begin
      r_bit_err_cnt <= '0;
    end else if (clr_cnt) begin
      r_bit_err_cnt <= '0;
    end else begin
      r_bit_err_cnt <= w_err_sum[32] ? 32'hFFFF_FFFF : w_err_sum[31:0];
    end
  end

  assign bit_err_cnt = r_bit_err_cnt;
`else
  assign bit_err_cnt = '0;
`endif

  assign locked        = (r_state == LOCKED);
  assign aligned_valid = locked;
  assign sof           = locked && (r_pos == '0);
  assign align_off     = r_off;
  assign aligned_data  = r_aligned;
  assign frame_cnt     = r_frame_cnt;
  assign miss_cnt      = r_miss_cnt;

endmodule

// File: tb/tb_tds_rx_frame_checker.sv
// tb_tds_rx_frame_checker: directed bench for the K28.5 aligner.
// Feeds bit-shifted frames of sync plus PRBS-7 payload and checks lock, alignment and counters.
module tb_tds_rx_frame_checker;

  localparam int          FRAME = 64;
  localparam logic [19:0] SYNC  = 20'hA0D7C;
`ifdef TDS_CHK_PRBS_EN
  localparam int ERR_SCALE = 1;
`else
  localparam int ERR_SCALE = 0;
`endif

  logic        clk    = 1'b0;
  logic        rstN   = 1'b1;
  logic [19:0] rxData = '0;
  logic        clrCnt = 1'b0;
  logic        locked;
  logic [4:0]  alignOff;
  logic [19:0] alignedData;
  logic        alignedValid;
  logic        sof;
  logic [31:0] frameCnt;
  logic [15:0] missCnt;
  logic [31:0] bitErrCnt;

  logic [59:0] bitBuf;
  int          bitCnt;
  logic [6:0]  prbsState;
  int          tbSent;
  int          corruptLeft;
  int          flipLeft;
  int          spuriousFrame;
  int          testsRun  = 0;
  int          failCount = 0;

  tds_rx_frame_checker dut (
    .gt0_rxusrclk2_out   (clk),
    .gt0_rxresetdone_out (rstN),
    .rx_data             (rxData),
    .clr_cnt             (clrCnt),
    .locked              (locked),
    .align_off           (alignOff),
    .aligned_data        (alignedData),
    .aligned_valid       (alignedValid),
    .sof                 (sof),
    .frame_cnt           (frameCnt),
    .miss_cnt            (missCnt),
    .bit_err_cnt         (bitErrCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Serialise one frame word into the shifted bit stream and present one rx word.
  task automatic sendRaw(input logic [19:0] w);
    bitBuf = bitBuf | (60'(w) << bitCnt);
    bitCnt += 20;
    rxData = bitBuf[19:0];
    bitBuf = bitBuf >> 20;
    bitCnt -= 20;
    @(posedge clk);
    #1;
  endtask

  task automatic genWord(output logic [19:0] w);
    logic [19:0] p;
    int          pos;
    int          frm;
    pos = tbSent % FRAME;
    frm = tbSent / FRAME;
    p   = '0;
    if (pos == 0) begin
      if (corruptLeft > 0) begin
        w = '0;
        corruptLeft--;
      end else begin
        w = SYNC;
      end
    end else begin
      for (int b = 0; b < 20; b++) begin
        p[b]      = prbsState[6] ^ prbsState[5];
        prbsState = {prbsState[5:0], p[b]};
      end
      w = p;
      if ((pos == FRAME - 1) && (flipLeft > 0)) begin
        w[19] = ~w[19];
        flipLeft--;
      end
      if ((pos == 20) && (frm == spuriousFrame)) w = SYNC;
    end
  endtask

  task automatic applyStimulus();
    logic [19:0] w;
    genWord(w);
    sendRaw(w);
    tbSent++;
  endtask

  // After two idle words, frame word f*FRAME+p is on aligned_data once tbSent = f*FRAME+p+3.
  task automatic runTo(input int f, input int p);
    while (tbSent < f * FRAME + p + 3) applyStimulus();
  endtask

  task automatic startScenario(input int offset, input int spur);
    rstN          = 1'b0;
    clrCnt        = 1'b0;
    rxData        = '0;
    bitBuf        = '0;
    bitCnt        = offset;
    prbsState     = 7'h01;
    tbSent        = 0;
    corruptLeft   = 0;
    flipLeft      = 0;
    spuriousFrame = spur;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    sendRaw('0);
    sendRaw('0);
  endtask

  initial begin
    #2 rstN = 1'b0;
    #1;
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_data", alignedData, 0);
    checkOutput("rst_frame", frameCnt, 0);

    // Offset 7: lock, frame counting, PRBS errors, misses, relock, clear, reset.
    startScenario(7, -1);
    runTo(2, 63);
    checkOutput("o7_prelock", locked, 0);
    runTo(3, 0);
    checkOutput("o7_locked", locked, 1);
    checkOutput("o7_valid", alignedValid, 1);
    checkOutput("o7_sof", sof, 1);
    checkOutput("o7_data", alignedData, SYNC);
    checkOutput("o7_off", alignOff, 7);
    checkOutput("o7_frame0", frameCnt, 0);
    runTo(3, 1);
    checkOutput("o7_sof_low", sof, 0);
    runTo(4, 0);
    checkOutput("o7_frame1", frameCnt, 1);
    runTo(4, 63);
    checkOutput("o7_frame1_hold", frameCnt, 1);
    runTo(5, 0);
    checkOutput("o7_frame2", frameCnt, 2);
    checkOutput("o7_err_clean", bitErrCnt, 0);

    flipLeft = 10;
    runTo(5, 63);
    checkOutput("err_lag", bitErrCnt, 0);
    runTo(6, 0);
    checkOutput("err_first", bitErrCnt, 1 * ERR_SCALE);
    runTo(16, 0);
    checkOutput("err_ten", bitErrCnt, 10 * ERR_SCALE);
    checkOutput("frame13", frameCnt, 13);

    corruptLeft = 2;
    runTo(17, 0);
    checkOutput("miss1_locked", locked, 1);
    checkOutput("miss1_sof", sof, 1);
    checkOutput("miss1_data", alignedData, 0);
    checkOutput("miss1_cnt", missCnt, 1);
    runTo(18, 0);
    checkOutput("miss2_cnt", missCnt, 2);
    checkOutput("miss2_locked", locked, 1);
    runTo(19, 0);
    checkOutput("miss_good_frame", frameCnt, 14);

    corruptLeft = 3;
    runTo(21, 63);
    checkOutput("miss4_locked", locked, 1);
    checkOutput("miss4_cnt", missCnt, 4);
    runTo(22, 0);
    checkOutput("miss5_unlock", locked, 0);
    checkOutput("miss5_valid", alignedValid, 0);
    checkOutput("miss5_sof", sof, 0);
    checkOutput("miss5_cnt", missCnt, 5);
    runTo(25, 63);
    checkOutput("relock_pre", locked, 0);
    runTo(26, 0);
    checkOutput("relock", locked, 1);
    checkOutput("relock_off", alignOff, 7);
    checkOutput("relock_frame", frameCnt, 14);

    runTo(26, 63);
    clrCnt = 1'b1;
    applyStimulus();
    clrCnt = 1'b0;
    checkOutput("clr_frame", frameCnt, 0);
    checkOutput("clr_miss", missCnt, 0);
    checkOutput("clr_err", bitErrCnt, 0);
    checkOutput("clr_locked", locked, 1);
    runTo(28, 0);
    checkOutput("clr_frame_next", frameCnt, 1);

    runTo(28, 30);
    rstN = 1'b0;
    #1;
    checkOutput("midrst_locked", locked, 0);
    checkOutput("midrst_valid", alignedValid, 0);
    checkOutput("midrst_sof", sof, 0);
    checkOutput("midrst_off", alignOff, 0);
    checkOutput("midrst_data", alignedData, 0);
    checkOutput("midrst_frame", frameCnt, 0);
    checkOutput("midrst_miss", missCnt, 0);
    checkOutput("midrst_err", bitErrCnt, 0);

    // Offset 19: highest legal offset.
    startScenario(19, -1);
    runTo(2, 63);
    checkOutput("o19_prelock", locked, 0);
    runTo(3, 0);
    checkOutput("o19_locked", locked, 1);
    checkOutput("o19_off", alignOff, 19);
    checkOutput("o19_data", alignedData, SYNC);
    checkOutput("o19_sof", sof, 1);
    runTo(4, 0);
    checkOutput("o19_frame1", frameCnt, 1);

    // Offset 0 with a spurious sync at position 20 of the second frame.
    startScenario(0, 1);
    runTo(1, 20);
    checkOutput("spur_data", alignedData, SYNC);
    checkOutput("spur_locked", locked, 0);
    runTo(2, 63);
    checkOutput("o0_prelock", locked, 0);
    runTo(3, 0);
    checkOutput("o0_locked", locked, 1);
    checkOutput("o0_off", alignOff, 0);
    checkOutput("o0_data", alignedData, SYNC);
    checkOutput("o0_sof", sof, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/tds_rx_frame_checker.md
# tds_rx_frame_checker

Receive-side frame aligner and pattern checker for a TDS serial link. It sits on the raw 20-bit parallel output of the 4.8 Gb/s GTP/GTX receive wrapper, in the recovered RX user-clock domain. It finds the K28.5 sync word at any of 20 bit offsets, locks to the frame cadence and emits bit-aligned words. It also counts frames, sync misses and PRBS-7 payload bit errors for the data-checker VIO/ILA.

## Interface
- FRAME_LEN, 64: words per frame including the sync word; legal range 4..4096.
- LOCK_CNT, 4: consecutive on-time sync words needed to enter LOCKED.
- MISS_MAX, 3: consecutive missed sync words in LOCKED that force HUNT.
- SYNC_WORD, 20'hA0D7C: K28.5 RD- then RD+ in LSB-first order, 10'h17C in [9:0] and 10'h283 in [19:10].

Ports:
- gt0_rxusrclk2_out  in  1  clock.
- gt0_rxresetdone_out  in  1  reset, asynchronous, active-low.
- rx_data  in  20  raw RX word; bit 0 is received first; a new word arrives every cycle.
- clr_cnt  in  1  synchronous clear of all statistics counters.
- locked  out  1  high in LOCKED.
- align_off  out  5  bit offset in use, 0..19.
- aligned_data  out  20  bit-aligned word.
- aligned_valid  out  1  high while locked.
- sof  out  1  aligned_data is the sync word.
- frame_cnt  out  32  on-time sync words seen in LOCKED; wraps.
- miss_cnt  out  16  missed expected sync words; saturates.
- bit_err_cnt  out  32  PRBS bit errors; saturates.

## Operation
- Window: prev <= cur and cur <= rx_data. win = {cur, prev}, 40 bits, with older bits low. The candidate word at offset k is win[k+19:k].
- States:
  - HUNT: compare SYNC_WORD at all 20 offsets every cycle. On any hit, take the lowest matching offset, latch align_off, set the position counter to 0 and go to VERIFY with good=1.
  - VERIFY: the position counter runs 0..FRAME_LEN-1 and wraps. When it wraps to 0, the word at align_off is checked. A match increments good; good==LOCK_CNT moves to LOCKED. A mismatch returns to HUNT. Sync words seen at other positions are ignored.
  - LOCKED: each on-time sync increments frame_cnt and clears the miss run. Each missed sync increments miss_cnt and the miss run; a miss run of MISS_MAX returns to HUNT. There is no realignment while LOCKED.
- Outputs:
  - aligned_data is registered from win at align_off in every state.
  - aligned_valid and locked are high only in LOCKED.
  - sof is high when aligned_valid is high and the position is 0.
- PRBS check (x^7+x^6+1):
  - For each aligned bit n: expected(n) = bit(n-7) XOR bit(n-6), computed over the concatenation of the previous and current aligned words.
  - The sync word and the word after it are not checked.
  - Checking runs only when aligned_valid is high.
  - Mismatch popcount is 0..20, held in a 5-bit count, and added to bit_err_cnt with saturation at 2^32-1.
- clr_cnt clears frame_cnt, miss_cnt and bit_err_cnt. If a clear and an increment fall in the same cycle, the clear wins. clr_cnt does not affect state or alignment.

## Timing
- On reset assertion, every output is 0 and the state is HUNT immediately; all internal registers are cleared. Reset assertion in mid-frame has the same effect.
- Latency:
  - rx_data word N affects win on cycle +1 (as cur) and is fully contained on cycle +2.
  - aligned_data is registered one cycle after win.
  - locked, sof and frame_cnt update in the same cycle as the corresponding aligned_data.
  - bit_err_cnt lags aligned_data by 1 cycle.
- Sync detection in HUNT is a single cycle (combinational compare on win). The VERIFY transition registers on the next edge.
- A sync pattern straddling two words is found through the 40-bit window and needs no extra cycles.
- Offset 0 and offset 19 are both legal and must be tested.

## Configuration
- TDS_CHK_PRBS_EN defined: the PRBS-7 checker and bit_err_cnt are built.
- TDS_CHK_PRBS_EN undefined: no PRBS logic is built and bit_err_cnt is tied to 0. Alignment, frame_cnt and miss_cnt are unchanged.

## Structure
- Package tds_chk_pkg holds:
  - the state enum (HUNT, VERIFY, LOCKED);
  - the SYNC_WORD constant;
  - K28.5 constants;
  - the offset width of 5;
  - the popcount width of 5.
- Sub-module tds_prbs7_chk holds the PRBS check: inputs are the previous and current aligned words plus an enable; output is the 5-bit error count, registered. It is instantiated only under TDS_CHK_PRBS_EN.

## Test plan
- Clean 64-word frames at offset 7 with PRBS payload: locked rises after the 4th sync, align_off=7, bit_err_cnt=0, and frame_cnt increments once per 64 cycles.
- Stream shifted to offset 19, then offset 0: each case locks with the matching align_off, and sof lines up with aligned_data=20'hA0D7C.
- One payload bit flipped per frame for 10 frames: bit_err_cnt=10. With TDS_CHK_PRBS_EN undefined, bit_err_cnt stays 0.
- Two sync words corrupted while LOCKED: miss_cnt=2 and locked stays high. Three consecutive corrupted sync words: locked falls on the third, then relock follows.
- A spurious sync word at position 20 during VERIFY: it is ignored and locking completes normally.
- Reset deasserted then reasserted mid-frame while LOCKED: all outputs 0 immediately. clr_cnt pulsed on a frame_cnt increment cycle: frame_cnt=0.
